// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path: sequencer states,
// decoder operation classes and the default address width.
package cpu_pkg;

  localparam int unsigned PC_W_DEFAULT = 8;

  // Sequencer state encoding, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StFetch  = 3'd1;
  localparam state_t StDecode = 3'd2;
  localparam state_t StExec   = 3'd3;
  localparam state_t StMem    = 3'd4;
  localparam state_t StWb     = 3'd5;

  localparam logic [1:0] OPC_ALU   = 2'b00;
  localparam logic [1:0] OPC_LOAD  = 2'b01;
  localparam logic [1:0] OPC_STORE = 2'b10;
  localparam logic [1:0] OPC_BRZ   = 2'b11;

  function automatic logic is_mem_op(input logic [1:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request waits without ready and flags
// expiry on the MAX_WAIT-th waiting cycle, unless ready arrives that cycle.
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic expired
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(MAX_WAIT - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!active || ready) begin
      count_d = '0;
    end else if (count_q != CntMax) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A ready in the limit cycle completes the transfer instead of faulting.
  assign expired = active && !ready && (count_q == Limit);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/write-back
// over a single-port memory and owns the program counter and retire count.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEFAULT,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [1:0]      op_class,
  input  logic            is_halt,
  input  logic            zero,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] data_addr,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [PC_W-1:0] mem_addr,
  output logic            ir_load,
  output logic            reg_write,
  output logic            wb_sel,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            fault,
  output logic [15:0]     retired
);

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     retired_q, retired_d;
  logic            fault_q, fault_d;
  logic            retire;
  logic            waiting;
  logic            expired;

  assign waiting = (state_q == StFetch) || (state_q == StMem);

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .active (waiting),
    .ready  (mem_ready),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (expired) begin
          state_d = StIdle;
        end
      end
      StDecode: begin
        if (is_halt) begin
          state_d = StIdle;
          retire  = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (op_q)
          OPC_ALU:   state_d = StWb;
          OPC_LOAD:  state_d = StMem;
          OPC_STORE: state_d = StMem;
          default: begin
            state_d = StFetch;
            retire  = 1'b1;
          end
        endcase
      end
      StMem: begin
        if (mem_ready) begin
          if (op_q == OPC_STORE) begin
            state_d = StFetch;
            retire  = 1'b1;
          end else begin
            state_d = StWb;
          end
        end else if (expired) begin
          state_d = StIdle;
        end
      end
      StWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_d      = op_q;
    addr_d    = addr_q;
    pc_d      = pc_q;
    fault_d   = fault_q;
    retired_d = retired_q + {15'd0, retire};

    // Decoder outputs are only trusted in DECODE, so hold the class from there.
    if (state_q == StDecode) op_d = op_class;

    if ((state_q == StExec) && is_mem_op(op_q)) addr_d = data_addr;

    if ((state_q == StFetch) && mem_ready) begin
      pc_d = pc_q + PC_W'(1);
    end else if ((state_q == StExec) && (op_q == OPC_BRZ) && zero) begin
      pc_d = branch_target;
    end

    if ((state_q == StIdle) && run) begin
      fault_d = 1'b0;
    end else if (waiting && expired) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= OPC_ALU;
      addr_q    <= '0;
      pc_q      <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end

  // Moore strobes straight off the state register; reset forces them low at once.
  always_comb begin
    mem_req   = waiting;
    mem_we    = (state_q == StMem) && (op_q == OPC_STORE);
    ir_load   = (state_q == StFetch) && mem_ready;
    reg_write = (state_q == StWb);
    wb_sel    = (state_q == StWb) && (op_q == OPC_LOAD);
    halted    = (state_q == StIdle);
    mem_addr  = '0;
    if (state_q == StFetch) begin
      mem_addr = pc_q;
    end else if (state_q == StMem) begin
      mem_addr = addr_q;
    end
  end

  assign pc      = pc_q;
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: walks each instruction class, stalls,
// timeout, mid-instruction reset and halt/restart against hand-computed values.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [1:0]  op_class;
  logic        is_halt;
  logic        zero;
  logic [7:0]  branch_target;
  logic [7:0]  data_addr;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic        ir_load;
  logic        reg_write;
  logic        wb_sel;
  logic [7:0]  pc;
  logic        halted;
  logic        fault;
  logic [15:0] retired;

  int n_assert = 0;
  int n_fail   = 0;

  cpu_sequencer #(
    .PC_W    (8),
    .MAX_WAIT(15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .op_class     (op_class),
    .is_halt      (is_halt),
    .zero         (zero),
    .branch_target(branch_target),
    .data_addr    (data_addr),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .ir_load      (ir_load),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .pc           (pc),
    .halted       (halted),
    .fault        (fault),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and let state-derived outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    op_class = OPC_ALU;
    is_halt = 1'b0;
    zero = 1'b0;
    branch_target = 8'h00;
    data_addr = 8'h00;
    mem_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_halted", 16'(halted), 16'd1);
    chk("rst_pc", 16'(pc), 16'h0);
    chk("rst_retired", retired, 16'h0);
    chk("rst_fault", 16'(fault), 16'd0);
    chk("rst_mem_req", 16'(mem_req), 16'd0);
    chk("rst_mem_we", 16'(mem_we), 16'd0);
    chk("rst_ir_load", 16'(ir_load), 16'd0);
    chk("rst_reg_write", 16'(reg_write), 16'd0);
    chk("rst_wb_sel", 16'(wb_sel), 16'd0);
    chk("rst_mem_addr", 16'(mem_addr), 16'h0);

    @(negedge clk);
    reset = 1'b0;
    run = 1'b1;

    // ALU at pc 0
    tick();
    run = 1'b0;
    chk("alu_fetch_req", 16'(mem_req), 16'd1);
    chk("alu_fetch_addr", 16'(mem_addr), 16'h00);
    chk("alu_ir_load", 16'(ir_load), 16'd1);
    chk("alu_fetch_halted", 16'(halted), 16'd0);
    op_class = OPC_ALU;
    tick();
    chk("alu_dec_pc", 16'(pc), 16'h01);
    chk("alu_dec_ir_load", 16'(ir_load), 16'd0);
    chk("alu_dec_req", 16'(mem_req), 16'd0);
    tick();
    chk("alu_exec_regw", 16'(reg_write), 16'd0);
    tick();
    chk("alu_wb_regw", 16'(reg_write), 16'd1);
    chk("alu_wb_sel", 16'(wb_sel), 16'd0);
    tick();
    chk("alu_next_fetch_req", 16'(mem_req), 16'd1);
    chk("alu_next_fetch_addr", 16'(mem_addr), 16'h01);
    chk("alu_retired", retired, 16'd1);

    // LOAD at pc 1, data 0x40, two stall cycles in MEM
    op_class = OPC_LOAD;
    data_addr = 8'h40;
    tick();
    chk("ld_dec_pc", 16'(pc), 16'h02);
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    chk("ld_mem_addr_1", 16'(mem_addr), 16'h40);
    chk("ld_mem_req_1", 16'(mem_req), 16'd1);
    chk("ld_mem_we", 16'(mem_we), 16'd0);
    tick();
    chk("ld_mem_addr_2", 16'(mem_addr), 16'h40);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("ld_mem_addr_3", 16'(mem_addr), 16'h40);
    chk("ld_mem_req_3", 16'(mem_req), 16'd1);
    tick();
    chk("ld_wb_regw", 16'(reg_write), 16'd1);
    chk("ld_wb_sel", 16'(wb_sel), 16'd1);
    chk("ld_wb_req", 16'(mem_req), 16'd0);
    tick();
    chk("ld_next_fetch_addr", 16'(mem_addr), 16'h02);
    chk("ld_retired", retired, 16'd2);

    // STORE at pc 2 to 0x40
    op_class = OPC_STORE;
    tick();
    chk("st_dec_we", 16'(mem_we), 16'd0);
    tick();
    chk("st_exec_we", 16'(mem_we), 16'd0);
    tick();
    chk("st_mem_we", 16'(mem_we), 16'd1);
    chk("st_mem_addr", 16'(mem_addr), 16'h40);
    chk("st_mem_regw", 16'(reg_write), 16'd0);
    tick();
    chk("st_fetch_we", 16'(mem_we), 16'd0);
    chk("st_fetch_addr", 16'(mem_addr), 16'h03);
    chk("st_retired", retired, 16'd3);

    // BRZ taken at pc 3 to 0x10
    op_class = OPC_BRZ;
    tick();
    zero = 1'b1;
    branch_target = 8'h10;
    tick();
    tick();
    chk("brz_taken_pc", 16'(pc), 16'h10);
    chk("brz_taken_addr", 16'(mem_addr), 16'h10);
    chk("brz_retired", retired, 16'd4);

    // BRZ taken to 0xFF, then fetch at 0xFF wraps pc, BRZ not taken keeps 0
    tick();
    branch_target = 8'hFF;
    tick();
    tick();
    chk("brz_ff_addr", 16'(mem_addr), 16'hFF);
    tick();
    chk("pc_wrap", 16'(pc), 16'h00);
    zero = 1'b0;
    branch_target = 8'h77;
    tick();
    tick();
    chk("brz_nt_pc", 16'(pc), 16'h00);
    chk("brz_nt_addr", 16'(mem_addr), 16'h00);
    chk("brz_nt_retired", retired, 16'd6);

    // Fetch timeout: ready low for 15 cycles
    mem_ready = 1'b0;
    #1;
    for (int i = 1; i < 15; i++) tick();
    chk("to_c15_halted", 16'(halted), 16'd0);
    chk("to_c15_fault", 16'(fault), 16'd0);
    chk("to_c15_addr", 16'(mem_addr), 16'h00);
    tick();
    chk("to_fault", 16'(fault), 16'd1);
    chk("to_halted", 16'(halted), 16'd1);
    chk("to_req_dropped", 16'(mem_req), 16'd0);
    chk("to_pc", 16'(pc), 16'h00);

    // Restart; ready on cycle 15 wins over the timer
    run = 1'b1;
    tick();
    run = 1'b0;
    op_class = OPC_ALU;
    chk("rs_fault_cleared", 16'(fault), 16'd0);
    for (int i = 1; i < 15; i++) tick();
    mem_ready = 1'b1;
    #1;
    chk("rs_c15_ir_load", 16'(ir_load), 16'd1);
    tick();
    chk("rs_no_fault", 16'(fault), 16'd0);
    chk("rs_not_halted", 16'(halted), 16'd0);
    chk("rs_pc", 16'(pc), 16'h01);
    tick();
    tick();
    tick();
    chk("rs_retired", retired, 16'd7);

    // Reset during MEM of a STORE
    op_class = OPC_STORE;
    data_addr = 8'h20;
    tick();
    tick();
    tick();
    chk("rm_mem_we", 16'(mem_we), 16'd1);
    reset = 1'b1;
    #1;
    chk("rm_we_drop", 16'(mem_we), 16'd0);
    chk("rm_req_drop", 16'(mem_req), 16'd0);
    chk("rm_pc", 16'(pc), 16'h00);
    chk("rm_retired", retired, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    run = 1'b1;

    // HALT, idle, restart; then HALT with run held high
    tick();
    run = 1'b0;
    is_halt = 1'b1;
    tick();
    chk("h_dec_pc", 16'(pc), 16'h01);
    tick();
    chk("h_idle_1", 16'(halted), 16'd1);
    chk("h_retired", retired, 16'd1);
    tick();
    chk("h_idle_2", 16'(halted), 16'd1);
    run = 1'b1;
    tick();
    chk("h_resume_addr", 16'(mem_addr), 16'h01);
    chk("h_resume_halted", 16'(halted), 16'd0);
    tick();
    tick();
    chk("h2_idle", 16'(halted), 16'd1);
    chk("h2_retired", retired, 16'd2);
    tick();
    chk("h2_restart_req", 16'(mem_req), 16'd1);
    chk("h2_restart_addr", 16'(mem_addr), 16'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control unit for the 8-bit CPU. It sequences fetch, decode, execute, memory and write-back over a shared single-port memory with a request/ready handshake. It owns the program counter and issues the load and write strobes to the instruction register, register file and memory. It sits between the instruction decoder/ALU and the memory, and replaces the free-running `pc + 1` next-PC logic.

## Interface
- `PC_W`, 8: program-counter and memory-address width.
- `MAX_WAIT`, 15: number of cycles `mem_ready` may stay low during a request before a fault is raised; range 1..255.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; forces the reset state immediately.
- `run` in 1: level; sampled only in IDLE, starts execution from the current `pc`.
- `op_class` in 2: from the decoder, valid in DECODE. 00 ALU, 01 LOAD, 10 STORE, 11 BRZ.
- `is_halt` in 1: from the decoder, valid in DECODE; takes priority over `op_class`.
- `zero` in 1: ALU zero flag, sampled in EXEC.
- `branch_target` in PC_W: immediate field, sampled in EXEC.
- `data_addr` in PC_W: ALU result used as the LOAD/STORE address.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write qualifier; high only in MEM for a STORE.
- `mem_addr` out PC_W: equals `pc` in FETCH and the latched `data_addr` in MEM; 0 otherwise.
- `ir_load` out 1: instruction-register capture strobe.
- `reg_write` out 1: register-file write enable.
- `wb_sel` out 1: write-back source. 0 selects the ALU, 1 selects memory read data.
- `pc` out PC_W: program counter.
- `halted` out 1: the sequencer is in IDLE.
- `fault` out 1: sticky memory-timeout flag.
- `retired` out 16: count of completed instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE:
  - `halted=1`.
  - If `run` is high, go to FETCH and clear `fault`.
- FETCH:
  - `mem_req=1`, `mem_addr=pc`.
  - On `mem_ready`: `ir_load=1`, `pc <= pc+1` (wraps 0xFF→0x00), go to DECODE.
- DECODE: one cycle.
  - If `is_halt`: go to IDLE and count the instruction as retired.
  - Otherwise: go to EXEC.
- EXEC, one cycle:
  - ALU: go to WB.
  - LOAD or STORE: latch `data_addr`, go to MEM.
  - BRZ: if `zero`, `pc <= branch_target`, else `pc` is unchanged. Retire, go to FETCH.
- MEM:
  - `mem_req=1`, with `mem_we=1` for a STORE.
  - On `mem_ready`, LOAD: go to WB.
  - On `mem_ready`, STORE: retire, go to FETCH.
- WB: one cycle.
  - `reg_write=1`; `wb_sel=1` for LOAD, 0 for ALU.
  - Retire, go to FETCH.
- Wait timer:
  - Counts consecutive cycles in FETCH or MEM with `mem_ready` low.
  - On reaching `MAX_WAIT`: set `fault=1`, drop `mem_req`, go to IDLE. `pc` keeps the faulting address plus 0 (no increment).
- `retired` increments by 1 per retired instruction and wraps at 0xFFFF. It is cleared only by reset.

## Timing
- Reset values: state IDLE, `pc=0`, `retired=0`, `fault=0`, `halted=1`, and every strobe 0 (`mem_req`, `mem_we`, `ir_load`, `reg_write`, `wb_sel`, `mem_addr=0`).
- Strobes are Moore outputs decoded from the state register, plus `mem_ready` for `ir_load`. They are never asserted in the cycle that reset deasserts.
- Latency from FETCH entry to the next FETCH, with `mem_ready` tied high:
  - ALU: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRZ: 3 cycles.
  - HALT: 2 cycles to IDLE.
- Each stall cycle on `mem_ready` adds 1 cycle. `mem_req`, `mem_we` and `mem_addr` hold stable while waiting.
- `mem_ready` outside FETCH or MEM is ignored.
- A ready arriving in the same cycle the timer hits `MAX_WAIT` wins: the transfer completes and there is no fault.
- Reset mid-instruction aborts immediately. No partial `reg_write` or memory write occurs after reset assertion.
- BRZ taken to `branch_target == pc`: a legal tight loop, no special handling.
- `run` held high after HALT restarts at the next cycle, fetching from the incremented `pc`.

## Structure
- Shared package `cpu_pkg`:
  - State enum.
  - `op_class` constants `OPC_ALU`, `OPC_LOAD`, `OPC_STORE`, `OPC_BRZ`.
  - Default `PC_W`.
- One sub-module, `mem_wait_timer`:
  - Inputs: `clk`, `reset`, `active`, `ready`.
  - Output: `expired`.
  - Counter width `$clog2(MAX_WAIT+1)`; clears whenever `active` is low or `ready` is high.
- The remainder is the FSM, the `pc` and `retired` registers, and the latched data address.

## Test plan
- Reset, then `run` pulse, with `mem_ready` tied high and an ALU instruction → `ir_load` at cycle 1, `reg_write` in cycle 4, `pc=1`, `retired=1`, FETCH again in cycle 5.
- LOAD with `data_addr=0x40` and 2 stall cycles in MEM → `mem_addr=0x40` held 3 cycles, then `wb_sel=1` with `reg_write=1`. STORE to the same address → `mem_we=1` only in MEM.
- BRZ with `zero=1`, `branch_target=0x10` → next fetch at 0x10. With `zero=0` at `pc=0xFF` (post-fetch) → `pc` wraps to 0x00.
- `mem_ready` held low in FETCH with `MAX_WAIT=15` → `fault=1` and `halted=1` after 15 cycles, `pc` unchanged. A ready on cycle 15 → no fault.
- Reset asserted during MEM of a STORE → `mem_we` drops in the same cycle, `pc=0`, `retired=0`.
- HALT instruction, then `run` → `halted=1` for 2 cycles after DECODE, resume at the next `pc`. `retired` wraps 0xFFFF→0x0000.
